// File: rtl/register_file_multiport.sv
// -----------------------------------------------------------------------------
// register_file_multiport
//
// Decode-stage register file with two combinational read ports, two write
// ports (port B wins on a same-index collision), an optional same-cycle
// write-to-read bypass and a per-register busy scoreboard used for hazard
// detection by a dual-issue / out-of-order-writeback datapath.
//
// Parameters
//   DATA_WIDTH : width of every register and data port
//   ADDR_WIDTH : register index width, depth = 2**ADDR_WIDTH
//   BYPASS     : 1 = this cycle's write data and busy-clear are visible on the
//                read ports before the edge; 0 = reads show stored state only
//   ZERO_REG   : 1 = index 0 reads as zero / not busy, writes and reserves to
//                index 0 are dropped
//
// Ports
//   Clk             : clock, all state changes on the rising edge
//   Reset           : synchronous, active-high; clears data and busy state
//   ReadRegister1/2 : read port indices
//   WriteRegisterA/B, WriteDataA/B, RegWriteA/B : write ports A and B
//   ReserveRegister, Reserve : mark one register busy at the next edge
//   ReadData1/2     : data for the read indices (combinational)
//   ReadBusy1/2     : busy flags for the read indices (combinational)
// -----------------------------------------------------------------------------
module register_file_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegisterA,
    input  logic [DATA_WIDTH-1:0] WriteDataA,
    input  logic                  RegWriteA,
    input  logic [ADDR_WIDTH-1:0] WriteRegisterB,
    input  logic [DATA_WIDTH-1:0] WriteDataB,
    input  logic                  RegWriteB,
    input  logic [ADDR_WIDTH-1:0] ReserveRegister,
    input  logic                  Reserve,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  ReadBusy1,
    output logic                  ReadBusy2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // Storage
    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_busy;

    // Qualified requests: enable gated with the hardwired-zero rule
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_rsv;
    logic [DEPTH-1:0]      w_busy_next;

    // Per-read-port intermediate values
    logic [DATA_WIDTH-1:0] w_arr_data1;
    logic [DATA_WIDTH-1:0] w_arr_data2;
    logic                  w_arr_busy1;
    logic                  w_arr_busy2;
    logic                  w_hit_a1;
    logic                  w_hit_b1;
    logic                  w_hit_r1;
    logic                  w_hit_a2;
    logic                  w_hit_b2;
    logic                  w_hit_r2;
    logic                  w_zero1;
    logic                  w_zero2;

    // Drop requests targeting the hardwired zero register
    always_comb begin
        w_wr_a = RegWriteA;
        w_wr_b = RegWriteB;
        w_rsv  = Reserve;
        if (ZERO_REG != 0) begin
            if (WriteRegisterA == IDX_ZERO) begin
                w_wr_a = 1'b0;
            end else begin
                w_wr_a = RegWriteA;
            end
            if (WriteRegisterB == IDX_ZERO) begin
                w_wr_b = 1'b0;
            end else begin
                w_wr_b = RegWriteB;
            end
            if (ReserveRegister == IDX_ZERO) begin
                w_rsv = 1'b0;
            end else begin
                w_rsv = Reserve;
            end
        end else begin
            w_wr_a = RegWriteA;
            w_wr_b = RegWriteB;
            w_rsv  = Reserve;
        end
    end

    // Next busy vector: writes clear, then the reserve sets, so a reserve to
    // the same index as a write leaves the register busy
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_a) begin
            w_busy_next[WriteRegisterA] = 1'b0;
        end else begin
            w_busy_next = w_busy_next;
        end
        if (w_wr_b) begin
            w_busy_next[WriteRegisterB] = 1'b0;
        end else begin
            w_busy_next = w_busy_next;
        end
        if (w_rsv) begin
            w_busy_next[ReserveRegister] = 1'b1;
        end else begin
            w_busy_next = w_busy_next;
        end
    end

    // Register array update; port B is applied last so it wins a collision
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= DATA_ZERO;
            end
        end else begin
            if (w_wr_a) begin
                r_regs[WriteRegisterA] <= WriteDataA;
            end
            if (w_wr_b) begin
                r_regs[WriteRegisterB] <= WriteDataB;
            end
        end
    end

    // Busy scoreboard update
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_busy <= {DEPTH{1'b0}};
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Array lookups and match detection for both read ports
    always_comb begin
        w_arr_data1 = r_regs[ReadRegister1];
        w_arr_data2 = r_regs[ReadRegister2];
        w_arr_busy1 = r_busy[ReadRegister1];
        w_arr_busy2 = r_busy[ReadRegister2];
        w_hit_a1    = w_wr_a && (WriteRegisterA == ReadRegister1);
        w_hit_b1    = w_wr_b && (WriteRegisterB == ReadRegister1);
        w_hit_r1    = w_rsv  && (ReserveRegister == ReadRegister1);
        w_hit_a2    = w_wr_a && (WriteRegisterA == ReadRegister2);
        w_hit_b2    = w_wr_b && (WriteRegisterB == ReadRegister2);
        w_hit_r2    = w_rsv  && (ReserveRegister == ReadRegister2);
        w_zero1     = (ZERO_REG != 0) && (ReadRegister1 == IDX_ZERO);
        w_zero2     = (ZERO_REG != 0) && (ReadRegister2 == IDX_ZERO);
    end

    // Read port 1. A pending reserve to the same index keeps the stored busy
    // flag visible instead of the write's clear, because the reserve will win
    // at the edge but must not itself be forwarded.
    always_comb begin
        ReadData1 = w_arr_data1;
        ReadBusy1 = w_arr_busy1;
        if (w_zero1) begin
            ReadData1 = DATA_ZERO;
            ReadBusy1 = 1'b0;
        end else if ((BYPASS != 0) && !Reset && (w_hit_a1 || w_hit_b1)) begin
            ReadData1 = w_hit_b1 ? WriteDataB : WriteDataA;
            ReadBusy1 = w_hit_r1 ? w_arr_busy1 : 1'b0;
        end else begin
            ReadData1 = w_arr_data1;
            ReadBusy1 = w_arr_busy1;
        end
    end

    // Read port 2, same rules as read port 1
    always_comb begin
        ReadData2 = w_arr_data2;
        ReadBusy2 = w_arr_busy2;
        if (w_zero2) begin
            ReadData2 = DATA_ZERO;
            ReadBusy2 = 1'b0;
        end else if ((BYPASS != 0) && !Reset && (w_hit_a2 || w_hit_b2)) begin
            ReadData2 = w_hit_b2 ? WriteDataB : WriteDataA;
            ReadBusy2 = w_hit_r2 ? w_arr_busy2 : 1'b0;
        end else begin
            ReadData2 = w_arr_data2;
            ReadBusy2 = w_arr_busy2;
        end
    end

endmodule

// File: tb/tb_register_file_multiport.sv
// -----------------------------------------------------------------------------
// Directed bench for register_file_multiport. Two instances share all inputs:
// u_byp has BYPASS=1, u_nob has BYPASS=0; both have ZERO_REG=1.
// -----------------------------------------------------------------------------
module tb_register_file_multiport;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ReadRegister1, ReadRegister2;
    logic [4:0]  WriteRegisterA, WriteRegisterB, ReserveRegister;
    logic [31:0] WriteDataA, WriteDataB;
    logic        RegWriteA, RegWriteB, Reserve;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        bz1_b, bz2_b, bz1_n, bz2_n;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    register_file_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) u_byp (
        .Clk(Clk), .Reset(Reset),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .WriteRegisterA(WriteRegisterA), .WriteDataA(WriteDataA), .RegWriteA(RegWriteA),
        .WriteRegisterB(WriteRegisterB), .WriteDataB(WriteDataB), .RegWriteB(RegWriteB),
        .ReserveRegister(ReserveRegister), .Reserve(Reserve),
        .ReadData1(rd1_b), .ReadData2(rd2_b), .ReadBusy1(bz1_b), .ReadBusy2(bz2_b)
    );

    register_file_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(1)) u_nob (
        .Clk(Clk), .Reset(Reset),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .WriteRegisterA(WriteRegisterA), .WriteDataA(WriteDataA), .RegWriteA(RegWriteA),
        .WriteRegisterB(WriteRegisterB), .WriteDataB(WriteDataB), .RegWriteB(RegWriteB),
        .ReserveRegister(ReserveRegister), .Reserve(Reserve),
        .ReadData1(rd1_n), .ReadData2(rd2_n), .ReadBusy1(bz1_n), .ReadBusy2(bz2_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Reset     = 1'b0;
        RegWriteA = 1'b0;
        RegWriteB = 1'b0;
        Reserve   = 1'b0;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd31;
        WriteRegisterA = 5'd0; WriteRegisterB = 5'd0; ReserveRegister = 5'd0;
        WriteDataA = 32'h0; WriteDataB = 32'h0;
        step();
        idle();
        #1;
        chk("rst_rd1_b", rd1_b, 32'h0);
        chk("rst_rd2_n", rd2_n, 32'h0);
        chk("rst_bz1_b", {31'h0, bz1_b}, 32'h0);
        chk("rst_bz2_n", {31'h0, bz2_n}, 32'h0);
        step();

        // Fill r8..r25, even indices via port A, odd via port B
        for (int i = 8; i <= 25; i++) begin
            idle();
            if ((i % 2) == 0) begin
                RegWriteA = 1'b1; WriteRegisterA = 5'(i); WriteDataA = 32'h1000_0000 + 32'(i);
            end else begin
                RegWriteB = 1'b1; WriteRegisterB = 5'(i); WriteDataB = 32'h1000_0000 + 32'(i);
            end
            step();
        end
        idle();
        for (int i = 8; i <= 25; i += 2) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(i + 1);
            #1;
            chk("fill_rd1_n", rd1_n, 32'h1000_0000 + 32'(i));
            chk("fill_rd2_n", rd2_n, 32'h1000_0000 + 32'(i + 1));
            chk("fill_rd1_b", rd1_b, 32'h1000_0000 + 32'(i));
            step();
        end
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd26;
        #1;
        chk("unwr_r7", rd1_n, 32'h0);
        chk("unwr_r26", rd2_b, 32'h0);
        step();

        // Same-index collision on r9: port B data wins
        RegWriteA = 1'b1; WriteRegisterA = 5'd9; WriteDataA = 32'hAAAA_AAAA;
        RegWriteB = 1'b1; WriteRegisterB = 5'd9; WriteDataB = 32'h5555_5555;
        ReadRegister1 = 5'd9;
        #1;
        chk("coll_byp_pre", rd1_b, 32'h5555_5555);
        chk("coll_nob_pre", rd1_n, 32'h1000_0009);
        step();
        idle();
        #1;
        chk("coll_byp_post", rd1_b, 32'h5555_5555);
        chk("coll_nob_post", rd1_n, 32'h5555_5555);
        step();

        // Bypass vs no bypass on r10
        RegWriteA = 1'b1; WriteRegisterA = 5'd10; WriteDataA = 32'hDEAD_BEEF;
        ReadRegister1 = 5'd10;
        #1;
        chk("byp_pre", rd1_b, 32'hDEAD_BEEF);
        chk("nob_pre", rd1_n, 32'h1000_000A);
        step();
        idle();
        #1;
        chk("byp_post", rd1_b, 32'hDEAD_BEEF);
        chk("nob_post", rd1_n, 32'hDEAD_BEEF);
        step();

        // Reserve r12: busy visible only after the edge
        Reserve = 1'b1; ReserveRegister = 5'd12;
        ReadRegister1 = 5'd12; ReadRegister2 = 5'd12;
        #1;
        chk("rsv_pre_b", {31'h0, bz1_b}, 32'h0);
        chk("rsv_pre_n", {31'h0, bz2_n}, 32'h0);
        step();
        idle();
        #1;
        chk("rsv_post_b", {31'h0, bz1_b}, 32'h1);
        chk("rsv_post_n", {31'h0, bz2_n}, 32'h1);
        // Write r12 via A clears busy
        RegWriteA = 1'b1; WriteRegisterA = 5'd12; WriteDataA = 32'h0C0C_0C0C;
        #1;
        chk("clr_pre_bz_b", {31'h0, bz1_b}, 32'h0);
        chk("clr_pre_bz_n", {31'h0, bz1_n}, 32'h1);
        chk("clr_pre_rd_b", rd2_b, 32'h0C0C_0C0C);
        chk("clr_pre_rd_n", rd2_n, 32'h1000_000C);
        step();
        idle();
        #1;
        chk("clr_post_bz_b", {31'h0, bz1_b}, 32'h0);
        chk("clr_post_bz_n", {31'h0, bz2_n}, 32'h0);
        chk("clr_post_rd_n", rd1_n, 32'h0C0C_0C0C);
        step();

        // Reserve and write r12 on the same edge: busy ends at 1
        Reserve = 1'b1; ReserveRegister = 5'd12;
        RegWriteA = 1'b1; WriteRegisterA = 5'd12; WriteDataA = 32'h1212_1212;
        #1;
        chk("rw_pre_bz_b", {31'h0, bz1_b}, 32'h0);
        step();
        #1;
        chk("rw_post_bz_b", {31'h0, bz1_b}, 32'h1);
        chk("rw_post_bz_n", {31'h0, bz1_n}, 32'h1);
        chk("rw_post_rd_n", rd1_n, 32'h1212_1212);
        // Again while already busy: bypassed busy shows the stored 1
        WriteDataA = 32'h3434_3434;
        #1;
        chk("rw2_pre_bz_b", {31'h0, bz2_b}, 32'h1);
        chk("rw2_pre_rd_b", rd2_b, 32'h3434_3434);
        step();
        idle();
        // Port B write clears busy
        RegWriteB = 1'b1; WriteRegisterB = 5'd12; WriteDataB = 32'h5656_5656;
        #1;
        chk("wb_pre_bz_b", {31'h0, bz2_b}, 32'h0);
        chk("wb_pre_rd_n", rd1_n, 32'h3434_3434);
        step();
        idle();
        #1;
        chk("wb_post_bz_n", {31'h0, bz1_n}, 32'h0);
        chk("wb_post_rd_n", rd1_n, 32'h5656_5656);
        step();

        // Register zero: writes and reserve dropped
        RegWriteA = 1'b1; WriteRegisterA = 5'd0; WriteDataA = 32'hFFFF_FFFF;
        RegWriteB = 1'b1; WriteRegisterB = 5'd0; WriteDataB = 32'hFFFF_FFFF;
        Reserve = 1'b1; ReserveRegister = 5'd0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        #1;
        chk("z_pre_rd_b", rd1_b, 32'h0);
        chk("z_pre_bz_b", {31'h0, bz1_b}, 32'h0);
        step();
        idle();
        #1;
        chk("z_post_rd_b", rd1_b, 32'h0);
        chk("z_post_rd_n", rd2_n, 32'h0);
        chk("z_post_bz_n", {31'h0, bz1_n}, 32'h0);
        step();

        // Fill r8..r15, reserve r13, then reset with a write and reserve pending
        for (int i = 8; i <= 15; i++) begin
            idle();
            RegWriteA = 1'b1; WriteRegisterA = 5'(i); WriteDataA = 32'h2000_0000 + 32'(i);
            step();
        end
        idle();
        Reserve = 1'b1; ReserveRegister = 5'd13;
        step();
        idle();
        ReadRegister1 = 5'd13;
        #1;
        chk("pre_rst_bz13", {31'h0, bz1_n}, 32'h1);
        Reset = 1'b1;
        RegWriteB = 1'b1; WriteRegisterB = 5'd14; WriteDataB = 32'h0000_1234;
        Reserve = 1'b1; ReserveRegister = 5'd15;
        ReadRegister1 = 5'd14;
        #1;
        chk("rst_nobyp_b", rd1_b, 32'h2000_000E);
        step();
        idle();
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
            #1;
            chk("post_rst_rd1_n", rd1_n, 32'h0);
            chk("post_rst_rd2_b", rd2_b, 32'h0);
            chk("post_rst_bz", {30'h0, bz1_n, bz2_b}, 32'h0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_file_multiport.md
# register_file_multiport

Parametrised successor to the single-write MIPS register file. It provides two read ports and two write ports, an optional write-to-read bypass, and a per-register busy scoreboard for hazard detection, so a dual-issue or out-of-order-writeback datapath can use one array. It sits in the decode stage: reads feed the ID/EX pipeline register, and writes come from the WB stage(s).

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- BYPASS, 1, 1 = same-cycle write data and busy-clear forwarded to reads; 0 = reads show array state only
- ZERO_REG, 1, 1 = register 0 hardwired to zero (writes and reserves to index 0 ignored)

Ports:
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high
- ReadRegister1  input  ADDR_WIDTH  read port 1 index
- ReadRegister2  input  ADDR_WIDTH  read port 2 index
- WriteRegisterA  input  ADDR_WIDTH  write port A index
- WriteDataA  input  DATA_WIDTH  write port A data
- RegWriteA  input  1  write port A enable
- WriteRegisterB  input  ADDR_WIDTH  write port B index
- WriteDataB  input  DATA_WIDTH  write port B data
- RegWriteB  input  1  write port B enable
- ReserveRegister  input  ADDR_WIDTH  register to mark busy
- Reserve  input  1  reserve enable
- ReadData1  output  DATA_WIDTH  data for ReadRegister1
- ReadData2  output  DATA_WIDTH  data for ReadRegister2
- ReadBusy1  output  1  busy flag for ReadRegister1
- ReadBusy2  output  1  busy flag for ReadRegister2

## Operation
- Storage: 2**ADDR_WIDTH × DATA_WIDTH array, plus a 2**ADDR_WIDTH-bit busy vector.
- Reset high at an edge: every register becomes 0 and every busy bit becomes 0. Reset overrides all writes and reserves in that cycle.
- Write: when RegWriteX is high at an edge, the array takes WriteDataX at WriteRegisterX. The same edge clears busy[WriteRegisterX].
- Write collision: when both ports write the same index, port B's data is stored (B priority).
- Reserve: when Reserve is high at an edge, busy[ReserveRegister] is set. If the same index is also written that edge, the reserve wins: data is stored and busy ends at 1.
- ZERO_REG=1: index 0 always reads 0 with busy 0. Writes and reserves to index 0 are dropped.
- Reads are combinational.
  - BYPASS=0: ReadDataN = array[ReadRegisterN] and ReadBusyN = busy[ReadRegisterN].
  - BYPASS=1, read index matches an enabled write this cycle (and is not index 0 under ZERO_REG): ReadDataN = that write's data, with port B over port A. ReadBusyN = 0, unless Reserve targets the same index this cycle, in which case ReadBusyN = busy[ReadRegisterN]. The reserve takes effect only after the edge.
  - Reset is not bypassed; reads during Reset show the current array.
- Reserve is never bypassed to ReadBusyN in the same cycle.

## Timing
- Write-to-read latency: 0 cycles with BYPASS=1; 1 edge with BYPASS=0.
- Reserve-to-busy latency: 1 edge.
- Outputs after reset: ReadData1/2 = 0 and ReadBusy1/2 = 0 for any index until the first write or reserve.
- Reset deasserted mid-sequence: state is exactly the reset state. Writes present in the reset cycle are lost.
- No X on outputs for any in-range index once Reset has been applied for one edge.

## Test plan
- Reset, then write 0x1000_0000+i to registers 8..25 via alternating ports A and B (one per cycle, BYPASS=0); read 2-by-2 -> each ReadData equals the written value; unwritten registers read 0.
- RegWriteA and RegWriteB both to r9 with 0xAAAA_AAAA and 0x5555_5555 in the same cycle -> r9 reads 0x5555_5555 after the edge.
- BYPASS=1: write r10=0xDEAD_BEEF while ReadRegister1=10 in the same cycle -> ReadData1=0xDEAD_BEEF before the edge. Repeat with BYPASS=0 -> old value before the edge, new value after.
- Reserve r12 -> ReadBusy1(r12)=1 next cycle; RegWriteA to r12 -> ReadBusy1=0 same cycle (BYPASS=1) and after the edge. Reserve and write r12 on the same edge -> busy stays 1 and data is updated.
- ZERO_REG=1: write r0=0xFFFF_FFFF and Reserve r0 -> ReadData1(r0)=0 and ReadBusy1=0.
- Fill r8..r15 and reserve r13, then assert Reset for one edge with RegWriteB to r14=0x1234 -> all reads are 0 and all busy flags are 0 afterwards.
